// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared types, constants and helpers for the branch predict unit.
//   bp_entry_t      : one predictor entry (valid, tag, target, ctr). Tag and
//                     counter fields are sized for the widest supported
//                     configuration (32-bit tag, up to 8-bit counter); unused
//                     upper bits are always written as zero.
//   bp_upd_e        : update command sent from the resolver to the table.
//   CTR_WEAK_T(w)   : weakly-taken counter value for a w-bit counter.
//   CTR_WEAK_NT(w)  : weakly-not-taken counter value for a w-bit counter.
//   CTR_MAX(w)      : saturation ceiling for a w-bit counter.
//   sat_update      : saturating increment/decrement of a counter.
// ---------------------------------------------------------------------------
package bp_pkg;

  localparam int TAG_MAX_W = 32;
  localparam int CTR_MAX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic [CTR_MAX_W-1:0] ctr;
  } bp_entry_t;

  typedef enum logic [2:0] {
    UPD_NONE,
    UPD_BR_TAKEN,
    UPD_BR_NOT_TAKEN,
    UPD_JAL,
    UPD_INVALIDATE
  } bp_upd_e;

  // MSB set, all lower bits clear.
  function automatic logic [CTR_MAX_W-1:0] CTR_WEAK_T(input int unsigned ctrW);
    return CTR_MAX_W'(64'd1 << (ctrW - 1));
  endfunction

  // MSB clear, all lower bits set (value 1 for a 2-bit counter).
  function automatic logic [CTR_MAX_W-1:0] CTR_WEAK_NT(input int unsigned ctrW);
    return CTR_MAX_W'((64'd1 << (ctrW - 1)) - 64'd1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] CTR_MAX(input int unsigned ctrW);
    return CTR_MAX_W'((64'd1 << ctrW) - 64'd1);
  endfunction

  // Counters stick at 0 and at the ceiling instead of wrapping.
  function automatic logic [CTR_MAX_W-1:0] sat_update(
    input logic [CTR_MAX_W-1:0] ctr,
    input logic                 taken,
    input int unsigned          ctrW
  );
    logic [CTR_MAX_W-1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_MAX(ctrW)) res = ctr + 1'b1;
    end else begin
      if (ctr != '0) res = ctr - 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// ---------------------------------------------------------------------------
// branch_predict_unit_if
// Bundles the fetch-side prediction signals and the EX-side resolution
// signals of the branch predict unit.
//   master : the pipeline (drives F_PC and the EX instruction, reads results)
//   slave  : the branch predict unit
// Fetch : F_PC -> F_PredTaken, F_PredTarget
// EX    : Cur_PC, Imm, Branch, jal, jalr, AluResult, EX_PredTaken,
//         EX_PredTarget -> PC_Four, BrPC, PcSel, NextPC
// Optional (macro BRANCH_STATS_EN): Stat_Ctrl, Stat_Mispred counters.
// ---------------------------------------------------------------------------
interface branch_predict_unit_if #(
  parameter int PC_W = 9
);

  logic [PC_W-1:0] F_PC;
  logic            F_PredTaken;
  logic [31:0]     F_PredTarget;

  logic [PC_W-1:0] Cur_PC;
  logic [31:0]     Imm;
  logic            Branch;
  logic            jal;
  logic            jalr;
  logic [31:0]     AluResult;
  logic            EX_PredTaken;
  logic [31:0]     EX_PredTarget;

  logic [31:0]     PC_Four;
  logic [31:0]     BrPC;
  logic            PcSel;
  logic [31:0]     NextPC;

`ifdef BRANCH_STATS_EN
  logic [31:0]     Stat_Ctrl;
  logic [31:0]     Stat_Mispred;

  modport master (
    output F_PC, Cur_PC, Imm, Branch, jal, jalr, AluResult,
           EX_PredTaken, EX_PredTarget,
    input  F_PredTaken, F_PredTarget, PC_Four, BrPC, PcSel, NextPC,
           Stat_Ctrl, Stat_Mispred
  );

  modport slave (
    input  F_PC, Cur_PC, Imm, Branch, jal, jalr, AluResult,
           EX_PredTaken, EX_PredTarget,
    output F_PredTaken, F_PredTarget, PC_Four, BrPC, PcSel, NextPC,
           Stat_Ctrl, Stat_Mispred
  );
`else
  modport master (
    output F_PC, Cur_PC, Imm, Branch, jal, jalr, AluResult,
           EX_PredTaken, EX_PredTarget,
    input  F_PredTaken, F_PredTarget, PC_Four, BrPC, PcSel, NextPC
  );

  modport slave (
    input  F_PC, Cur_PC, Imm, Branch, jal, jalr, AluResult,
           EX_PredTaken, EX_PredTarget,
    output F_PredTaken, F_PredTarget, PC_Four, BrPC, PcSel, NextPC
  );
`endif

endinterface

// File: rtl/bp_table.sv
// ---------------------------------------------------------------------------
// bp_table
// Predictor entry array: tagged BTB plus saturating counters.
//   clk, reset     : clock, synchronous active-high reset
//   rd_idx_i/tag_i : combinational fetch lookup
//   rd_hit_o       : entry valid and tag matches
//   rd_taken_o     : counter MSB of the addressed entry
//   rd_target_o    : stored target of the addressed entry
//   upd_op_i       : update command from the resolver
//   upd_idx_i/tag_i: entry and tag the update applies to
//   upd_target_i   : resolved target to store
// The write port does its own hit check against the addressed entry, so the
// resolver only needs to say what happened, not how the entry looks.
// ---------------------------------------------------------------------------
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [31:0]      rd_tag_i,
  output logic             rd_hit_o,
  output logic             rd_taken_o,
  output logic [31:0]      rd_target_o,
  input  bp_upd_e          upd_op_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic [31:0]      upd_tag_i,
  input  logic [31:0]      upd_target_i
);

  bp_entry_t entries_q [ENTRIES];
  bp_entry_t updEntry;
  bp_entry_t newEntry_d;
  logic      updHit;
  logic      writeEn_d;

  // Fetch lookup reads the registered array only, so an update in the same
  // cycle becomes visible one cycle later.
  assign rd_hit_o    = entries_q[rd_idx_i].valid && (entries_q[rd_idx_i].tag == rd_tag_i);
  assign rd_taken_o  = entries_q[rd_idx_i].ctr[CTR_W-1];
  assign rd_target_o = entries_q[rd_idx_i].target;

  // Build the replacement entry for the EX index. Allocation sets a fresh
  // counter; a hit keeps training the existing counter. Commands that find
  // nothing to act on leave the write enable low.
  always_comb begin
    updEntry   = entries_q[upd_idx_i];
    updHit     = updEntry.valid && (updEntry.tag == upd_tag_i);
    newEntry_d = updEntry;
    writeEn_d  = 1'b0;
    case (upd_op_i)
      UPD_BR_TAKEN: begin
        writeEn_d         = 1'b1;
        newEntry_d.valid  = 1'b1;
        newEntry_d.tag    = upd_tag_i;
        newEntry_d.target = upd_target_i;
        newEntry_d.ctr    = updHit ? sat_update(updEntry.ctr, 1'b1, CTR_W) : CTR_WEAK_T(CTR_W);
      end
      UPD_BR_NOT_TAKEN: begin
        if (updHit) begin
          writeEn_d      = 1'b1;
          newEntry_d.ctr = sat_update(updEntry.ctr, 1'b0, CTR_W);
        end
      end
      UPD_JAL: begin
        writeEn_d         = 1'b1;
        newEntry_d.valid  = 1'b1;
        newEntry_d.tag    = upd_tag_i;
        newEntry_d.target = upd_target_i;
        newEntry_d.ctr    = CTR_MAX(CTR_W);
      end
      UPD_INVALIDATE: begin
        if (updHit) begin
          writeEn_d        = 1'b1;
          newEntry_d.valid = 1'b0;
        end
      end
      default: begin
        writeEn_d = 1'b0;
      end
    endcase
  end

  // Reset wins over any pending update, leaving every entry invalid with a
  // weakly-not-taken counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT(CTR_W)};
      end
    end else if (writeEn_d) begin
      entries_q[upd_idx_i] <= newEntry_d;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
// Fetch-side branch predictor plus execute-stage branch resolver.
//   clk, reset : clock, synchronous active-high reset
//   bus        : branch_predict_unit_if.slave
//     fetch    : F_PC in; F_PredTaken, F_PredTarget out (combinational)
//     EX       : Cur_PC, Imm, Branch, jal, jalr, AluResult, EX_PredTaken,
//                EX_PredTarget in; PC_Four, BrPC, PcSel, NextPC out
//                (combinational)
// Optional feature macro BRANCH_STATS_EN: adds Stat_Ctrl (resolved control
// instructions) and Stat_Mispred (redirect cycles) counters on the bus.
// Parameters: PC_W (PC width), ENTRIES (power of two >= 2), CTR_W (>= 1,
// <= 8). PC_W must match the PC_W of the connected interface.
// ---------------------------------------------------------------------------
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input logic                 clk,
  input logic                 reset,
  branch_predict_unit_if.slave bus
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_SH = IDX_W + 2;

  logic [PC_W-1:0]  fetchPc;
  logic [PC_W-1:0]  exPc;
  logic [31:0]      fetchPc32;
  logic [31:0]      exPc32;
  logic [IDX_W-1:0] fetchIdx;
  logic [IDX_W-1:0] exIdx;
  logic [31:0]      fetchTag;
  logic [31:0]      exTag;
  logic             rdHit;
  logic             rdTaken;
  logic [31:0]      rdTarget;
  logic             predTaken;
  logic [31:0]      pcFour;
  logic [31:0]      brPc;
  logic             brFlagTaken;
  logic             resolvedTaken;
  logic             mispredict;
  logic             isCtrl;
  bp_upd_e          updOp;

  // PCs are zero-extended to 32 bits before any address arithmetic. Shifting
  // out the index and offset bits leaves the tag; when the PC has no bits
  // above the index the tag is always zero, so every valid entry hits.
  assign fetchPc   = bus.F_PC;
  assign exPc      = bus.Cur_PC;
  assign fetchPc32 = 32'(fetchPc);
  assign exPc32    = 32'(exPc);
  assign fetchIdx  = IDX_W'(fetchPc32 >> 2);
  assign exIdx     = IDX_W'(exPc32 >> 2);
  assign fetchTag  = fetchPc32 >> TAG_SH;
  assign exTag     = exPc32 >> TAG_SH;

  bp_table #(
    .ENTRIES (ENTRIES),
    .CTR_W   (CTR_W),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk          (clk),
    .reset        (reset),
    .rd_idx_i     (fetchIdx),
    .rd_tag_i     (fetchTag),
    .rd_hit_o     (rdHit),
    .rd_taken_o   (rdTaken),
    .rd_target_o  (rdTarget),
    .upd_op_i     (updOp),
    .upd_idx_i    (exIdx),
    .upd_tag_i    (exTag),
    .upd_target_i (brPc)
  );

  // The fetch prediction is held off while reset is asserted so nothing
  // leaks out of the table before it has been cleared.
  assign predTaken        = !reset && rdHit && rdTaken;
  assign bus.F_PredTaken  = predTaken;
  assign bus.F_PredTarget = predTaken ? rdTarget : 32'd0;

  // Resolve the EX instruction: actual target, fall-through, and whether the
  // prediction it carried was wrong in direction or in target.
  always_comb begin
    pcFour        = exPc32 + 32'd4;
    brPc          = bus.jalr ? {bus.AluResult[31:1], 1'b0} : exPc32 + (bus.Imm <<< 1);
    brFlagTaken   = bus.Branch && (bus.AluResult == 32'd1);
    resolvedTaken = brFlagTaken || bus.jal || bus.jalr;
    isCtrl        = bus.Branch || bus.jal || bus.jalr;
    if (resolvedTaken) begin
      mispredict = !bus.EX_PredTaken || (bus.EX_PredTarget != brPc);
    end else begin
      mispredict = bus.EX_PredTaken;
    end
  end

  assign bus.PC_Four = pcFour;
  assign bus.BrPC    = brPc;
  assign bus.PcSel   = mispredict;
  assign bus.NextPC  = resolvedTaken ? brPc : pcFour;

  // Translate the resolved instruction into a table command. jalr is never
  // worth predicting, and a non-control instruction that arrived with a taken
  // prediction only got it by aliasing, so both knock out a hitting entry.
  always_comb begin
    updOp = UPD_NONE;
    if (bus.jal) begin
      updOp = UPD_JAL;
    end else if (bus.jalr) begin
      updOp = UPD_INVALIDATE;
    end else if (bus.Branch) begin
      updOp = brFlagTaken ? UPD_BR_TAKEN : UPD_BR_NOT_TAKEN;
    end else if (bus.EX_PredTaken) begin
      updOp = UPD_INVALIDATE;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] statCtrl_q;
  logic [31:0] statCtrl_d;
  logic [31:0] statMispred_q;
  logic [31:0] statMispred_d;

  // Free-running event counters; they wrap naturally at 2^32.
  always_comb begin
    statCtrl_d    = statCtrl_q + 32'(isCtrl);
    statMispred_d = statMispred_q + 32'(mispredict);
  end

  // Cleared by reset; the reset-cycle instruction is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      statCtrl_q    <= '0;
      statMispred_q <= '0;
    end else begin
      statCtrl_q    <= statCtrl_d;
      statMispred_q <= statMispred_d;
    end
  end

  assign bus.Stat_Ctrl    = statCtrl_q;
  assign bus.Stat_Mispred = statMispred_q;
`else
  logic unusedCtrl;
  assign unusedCtrl = isCtrl;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
// Directed bench for branch_predict_unit (PC_W=9, ENTRIES=16, CTR_W=2).
// Index = PC[5:2], tag = PC[8:6]. Inputs change 1 time unit after a rising
// edge and outputs are checked before the next rising edge.
// With BRANCH_STATS_EN defined the statistics counters are compared against
// a bench scoreboard.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

  logic clk;
  logic reset;
  int   vecs;
  int   miscompares;
  int   expCtrl;
  int   expMis;

  branch_predict_unit_if #(.PC_W(9)) bus ();

  branch_predict_unit #(
    .PC_W    (9),
    .ENTRIES (16),
    .CTR_W   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clearEx();
    bus.Cur_PC        = '0;
    bus.Imm           = '0;
    bus.Branch        = 1'b0;
    bus.jal           = 1'b0;
    bus.jalr          = 1'b0;
    bus.AluResult     = '0;
    bus.EX_PredTaken  = 1'b0;
    bus.EX_PredTarget = '0;
  endtask

  task automatic driveEx(input logic br, input logic jl, input logic jr,
                         input logic [8:0] pc, input logic [31:0] imm,
                         input logic [31:0] alu, input logic pt,
                         input logic [31:0] ptgt);
    bus.Branch        = br;
    bus.jal           = jl;
    bus.jalr          = jr;
    bus.Cur_PC        = pc;
    bus.Imm           = imm;
    bus.AluResult     = alu;
    bus.EX_PredTaken  = pt;
    bus.EX_PredTarget = ptgt;
  endtask

  // Advance one rising edge; the scoreboard follows what the stats counters
  // should do on that edge given the bench's own expectation of the cycle.
  task automatic tick(input logic isCtrl, input logic expSel);
    @(posedge clk);
    if (reset) begin
      expCtrl = 0;
      expMis  = 0;
    end else begin
      expCtrl += int'(isCtrl);
      expMis  += int'(expSel);
    end
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus.F_PC = 9'h010;
    clearEx();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    vecs++; if (bus.F_PredTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pred: got %b expected 0", bus.F_PredTaken); end
    vecs++; if (bus.F_PredTarget !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_target: got %h expected 0", bus.F_PredTarget); end
    vecs++; if (bus.PC_Four !== 32'h4) begin miscompares++; $display("[TB] FAIL reset_pcfour: got %h expected 4", bus.PC_Four); end
    reset = 1'b0;
    tick(1'b0, 1'b0);
    vecs++; if (bus.F_PredTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_pred: got %b expected 0", bus.F_PredTaken); end
`ifdef BRANCH_STATS_EN
    vecs++; if (bus.Stat_Ctrl !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_stat_ctrl: got %0d expected 0", bus.Stat_Ctrl); end
    vecs++; if (bus.Stat_Mispred !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_stat_mis: got %0d expected 0", bus.Stat_Mispred); end
`endif
  endtask

  task automatic test_branch_alloc();
    bus.F_PC = 9'h020;
    driveEx(1'b1, 1'b0, 1'b0, 9'h020, 32'd8, 32'd1, 1'b0, 32'h0);
    #1;
    vecs++; if (bus.BrPC !== 32'h30) begin miscompares++; $display("[TB] FAIL alloc_brpc: got %h expected 30", bus.BrPC); end
    vecs++; if (bus.PcSel !== 1'b1) begin miscompares++; $display("[TB] FAIL alloc_pcsel: got %b expected 1", bus.PcSel); end
    vecs++; if (bus.NextPC !== 32'h30) begin miscompares++; $display("[TB] FAIL alloc_nextpc: got %h expected 30", bus.NextPC); end
    vecs++; if (bus.PC_Four !== 32'h24) begin miscompares++; $display("[TB] FAIL alloc_pcfour: got %h expected 24", bus.PC_Four); end
    vecs++; if (bus.F_PredTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL alloc_nobypass: got %b expected 0", bus.F_PredTaken); end
    tick(1'b1, 1'b1);
    clearEx();
    #1;
    vecs++; if (bus.F_PredTaken !== 1'b1) begin miscompares++; $display("[TB] FAIL alloc_pred: got %b expected 1", bus.F_PredTaken); end
    vecs++; if (bus.F_PredTarget !== 32'h30) begin miscompares++; $display("[TB] FAIL alloc_target: got %h expected 30", bus.F_PredTarget); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) begin
      driveEx(1'b1, 1'b0, 1'b0, 9'h020, 32'd8, 32'd1, 1'b1, 32'h30);
      #1;
      vecs++; if (bus.PcSel !== 1'b0) begin miscompares++; $display("[TB] FAIL sat_taken_pcsel[%0d]: got %b expected 0", i, bus.PcSel); end
      tick(1'b1, 1'b0);
    end
    driveEx(1'b1, 1'b0, 1'b0, 9'h020, 32'd8, 32'd0, 1'b1, 32'h30);
    #1;
    vecs++; if (bus.PcSel !== 1'b1) begin miscompares++; $display("[TB] FAIL nt1_pcsel: got %b expected 1", bus.PcSel); end
    vecs++; if (bus.NextPC !== 32'h24) begin miscompares++; $display("[TB] FAIL nt1_nextpc: got %h expected 24", bus.NextPC); end
    tick(1'b1, 1'b1);
    clearEx();
    #1;
    vecs++; if (bus.F_PredTaken !== 1'b1) begin miscompares++; $display("[TB] FAIL nt1_pred: got %b expected 1", bus.F_PredTaken); end
    vecs++; if (bus.F_PredTarget !== 32'h30) begin miscompares++; $display("[TB] FAIL nt1_target: got %h expected 30", bus.F_PredTarget); end
    driveEx(1'b1, 1'b0, 1'b0, 9'h020, 32'd8, 32'd0, 1'b1, 32'h30);
    #1;
    vecs++; if (bus.PcSel !== 1'b1) begin miscompares++; $display("[TB] FAIL nt2_pcsel: got %b expected 1", bus.PcSel); end
    tick(1'b1, 1'b1);
    clearEx();
    #1;
    vecs++; if (bus.F_PredTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL nt2_pred: got %b expected 0", bus.F_PredTaken); end
    vecs++; if (bus.F_PredTarget !== 32'h0) begin miscompares++; $display("[TB] FAIL nt2_target: got %h expected 0", bus.F_PredTarget); end
  endtask

  task automatic test_jalr();
    driveEx(1'b1, 1'b0, 1'b0, 9'h020, 32'd8, 32'd1, 1'b0, 32'h0);
    #1;
    vecs++; if (bus.PcSel !== 1'b1) begin miscompares++; $display("[TB] FAIL retrain_pcsel: got %b expected 1", bus.PcSel); end
    tick(1'b1, 1'b1);
    clearEx();
    #1;
    vecs++; if (bus.F_PredTaken !== 1'b1) begin miscompares++; $display("[TB] FAIL retrain_pred: got %b expected 1", bus.F_PredTaken); end
    driveEx(1'b0, 1'b0, 1'b1, 9'h020, 32'd0, 32'h103, 1'b1, 32'h30);
    #1;
    vecs++; if (bus.BrPC !== 32'h102) begin miscompares++; $display("[TB] FAIL jalr_brpc: got %h expected 102", bus.BrPC); end
    vecs++; if (bus.PcSel !== 1'b1) begin miscompares++; $display("[TB] FAIL jalr_pcsel: got %b expected 1", bus.PcSel); end
    vecs++; if (bus.NextPC !== 32'h102) begin miscompares++; $display("[TB] FAIL jalr_nextpc: got %h expected 102", bus.NextPC); end
    vecs++; if (bus.F_PredTaken !== 1'b1) begin miscompares++; $display("[TB] FAIL jalr_oldpred: got %b expected 1", bus.F_PredTaken); end
    tick(1'b1, 1'b1);
    clearEx();
    #1;
    vecs++; if (bus.F_PredTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL jalr_inval_pred: got %b expected 0", bus.F_PredTaken); end
    vecs++; if (bus.F_PredTarget !== 32'h0) begin miscompares++; $display("[TB] FAIL jalr_inval_target: got %h expected 0", bus.F_PredTarget); end
    driveEx(1'b0, 1'b0, 1'b1, 9'h020, 32'd0, 32'h103, 1'b1, 32'h102);
    #1;
    vecs++; if (bus.PcSel !== 1'b0) begin miscompares++; $display("[TB] FAIL jalr_ok_pcsel: got %b expected 0", bus.PcSel); end
    tick(1'b1, 1'b0);
  endtask

  task automatic test_jal();
    bus.F_PC = 9'h040;
    driveEx(1'b0, 1'b1, 1'b0, 9'h040, 32'hFFFF_FFFC, 32'd0, 1'b0, 32'h0);
    #1;
    vecs++; if (bus.BrPC !== 32'h38) begin miscompares++; $display("[TB] FAIL jal_brpc: got %h expected 38", bus.BrPC); end
    vecs++; if (bus.PcSel !== 1'b1) begin miscompares++; $display("[TB] FAIL jal_pcsel: got %b expected 1", bus.PcSel); end
    vecs++; if (bus.NextPC !== 32'h38) begin miscompares++; $display("[TB] FAIL jal_nextpc: got %h expected 38", bus.NextPC); end
    tick(1'b1, 1'b1);
    clearEx();
    #1;
    vecs++; if (bus.F_PredTaken !== 1'b1) begin miscompares++; $display("[TB] FAIL jal_pred: got %b expected 1", bus.F_PredTaken); end
    vecs++; if (bus.F_PredTarget !== 32'h38) begin miscompares++; $display("[TB] FAIL jal_target: got %h expected 38", bus.F_PredTarget); end
    bus.F_PC = 9'h000;
    #1;
    vecs++; if (bus.F_PredTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL tag_miss_pred: got %b expected 0", bus.F_PredTaken); end
    bus.F_PC = 9'h040;
    driveEx(1'b0, 1'b1, 1'b0, 9'h040, 32'hFFFF_FFFC, 32'd0, 1'b1, 32'h38);
    #1;
    vecs++; if (bus.PcSel !== 1'b0) begin miscompares++; $display("[TB] FAIL jal_hit_pcsel: got %b expected 0", bus.PcSel); end
    tick(1'b1, 1'b0);
    driveEx(1'b0, 1'b1, 1'b0, 9'h040, 32'hFFFF_FFFC, 32'd0, 1'b1, 32'h3C);
    #1;
    vecs++; if (bus.PcSel !== 1'b1) begin miscompares++; $display("[TB] FAIL jal_badtgt_pcsel: got %b expected 1", bus.PcSel); end
    tick(1'b1, 1'b1);
    driveEx(1'b0, 1'b0, 1'b0, 9'h040, 32'd0, 32'd0, 1'b1, 32'h38);
    #1;
    vecs++; if (bus.PcSel !== 1'b1) begin miscompares++; $display("[TB] FAIL alias_pcsel: got %b expected 1", bus.PcSel); end
    vecs++; if (bus.NextPC !== 32'h44) begin miscompares++; $display("[TB] FAIL alias_nextpc: got %h expected 44", bus.NextPC); end
    tick(1'b0, 1'b1);
    clearEx();
    #1;
    vecs++; if (bus.F_PredTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL alias_inval_pred: got %b expected 0", bus.F_PredTaken); end
  endtask

  task automatic test_back_to_back();
    bus.F_PC = 9'h040;
    driveEx(1'b0, 1'b1, 1'b0, 9'h040, 32'hFFFF_FFFC, 32'd0, 1'b0, 32'h0);
    tick(1'b1, 1'b1);
    driveEx(1'b0, 1'b1, 1'b0, 9'h000, 32'h10, 32'd0, 1'b0, 32'h0);
    #1;
    vecs++; if (bus.BrPC !== 32'h20) begin miscompares++; $display("[TB] FAIL same_brpc: got %h expected 20", bus.BrPC); end
    vecs++; if (bus.PcSel !== 1'b1) begin miscompares++; $display("[TB] FAIL same_pcsel: got %b expected 1", bus.PcSel); end
    vecs++; if (bus.F_PredTaken !== 1'b1) begin miscompares++; $display("[TB] FAIL same_old_pred: got %b expected 1", bus.F_PredTaken); end
    vecs++; if (bus.F_PredTarget !== 32'h38) begin miscompares++; $display("[TB] FAIL same_old_target: got %h expected 38", bus.F_PredTarget); end
    tick(1'b1, 1'b1);
    clearEx();
    #1;
    vecs++; if (bus.F_PredTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL same_new_oldpc: got %b expected 0", bus.F_PredTaken); end
    bus.F_PC = 9'h000;
    #1;
    vecs++; if (bus.F_PredTaken !== 1'b1) begin miscompares++; $display("[TB] FAIL same_new_pred: got %b expected 1", bus.F_PredTaken); end
    vecs++; if (bus.F_PredTarget !== 32'h20) begin miscompares++; $display("[TB] FAIL same_new_target: got %h expected 20", bus.F_PredTarget); end
`ifdef BRANCH_STATS_EN
    vecs++; if (bus.Stat_Ctrl !== 32'(expCtrl)) begin miscompares++; $display("[TB] FAIL stat_ctrl: got %0d expected %0d", bus.Stat_Ctrl, expCtrl); end
    vecs++; if (bus.Stat_Mispred !== 32'(expMis)) begin miscompares++; $display("[TB] FAIL stat_mis: got %0d expected %0d", bus.Stat_Mispred, expMis); end
`endif
  endtask

  task automatic test_reset_midrun();
    bus.F_PC = 9'h000;
    reset    = 1'b1;
    driveEx(1'b1, 1'b0, 1'b0, 9'h020, 32'd8, 32'd1, 1'b0, 32'h0);
    #1;
    vecs++; if (bus.PcSel !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_comb_pcsel: got %b expected 1", bus.PcSel); end
    vecs++; if (bus.F_PredTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_gate_pred: got %b expected 0", bus.F_PredTaken); end
    tick(1'b1, 1'b1);
    clearEx();
    reset = 1'b0;
    tick(1'b0, 1'b0);
    vecs++; if (bus.F_PredTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_cleared_pred: got %b expected 0", bus.F_PredTaken); end
    bus.F_PC = 9'h020;
    #1;
    vecs++; if (bus.F_PredTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_discard_pred: got %b expected 0", bus.F_PredTaken); end
`ifdef BRANCH_STATS_EN
    vecs++; if (bus.Stat_Ctrl !== 32'(expCtrl)) begin miscompares++; $display("[TB] FAIL rst_stat_ctrl: got %0d expected %0d", bus.Stat_Ctrl, expCtrl); end
    vecs++; if (bus.Stat_Mispred !== 32'(expMis)) begin miscompares++; $display("[TB] FAIL rst_stat_mis: got %0d expected %0d", bus.Stat_Mispred, expMis); end
`endif
  endtask

  // Scenarios run in order; each one builds on the table state the previous
  // one left behind.
  initial begin
    vecs        = 0;
    miscompares = 0;
    expCtrl     = 0;
    expMis      = 0;
    reset       = 1'b1;
    bus.F_PC    = '0;
    clearEx();
    test_reset();
    test_branch_alloc();
    test_saturate();
    test_jalr();
    test_jal();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
